fetch_stage: RTL

- Fetch stage and F/D pipeline register of the P7 five-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Computes the next PC from the control decisions the D-stage controller makes on the instruction currently in D (isj, isb, PCSel).
- Latches the fetched word into D with its PC, a delay-slot flag and the fetch exception code, for CP0 / EPC handling.

---
 rtl/fetch_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - P7 MIPS fetch stage: PC register, next-PC select, F/D pipeline register
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_END     = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        isj,
    input  logic        isb,
    input  logic [1:0]  PCSel,
    input  logic [31:0] rs_val_D,
    input  logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic        BD_D,
    output logic [4:0]  exc_D
);

    logic        fault_F;
    logic [31:0] word_F;
    logic [4:0]  exc_F;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic [31:0] next_pc;

    assign fault_F = (pc_F[1:0] != 2'b00) || (pc_F < IM_BASE) || (pc_F > IM_END);
    assign word_F  = fault_F ? 32'h0000_0000 : instr_F;
    assign exc_F   = fault_F ? 5'd4 : 5'd0;

    assign btarget = PC_D + 32'd4 + {{14{IR_D[15]}}, IR_D[15:0], 2'b00};
    assign jtarget = {PC_D[31:28], IR_D[25:0], 2'b00};

    // Redirects come from the instruction in D, so instr_F never reaches next_pc.
    always_comb begin
        next_pc = pc_F + 32'd4;
        if (req)
            next_pc = HANDLER_PC;
        else if (eret)
            next_pc = epc;
        else if (stall)
            next_pc = pc_F;
        else if (PCSel == 2'd1 && isj)
            next_pc = jtarget;
        else if (PCSel == 2'd1 && isb)
            next_pc = btarget;
        else if (PCSel == 2'd2)
            next_pc = rs_val_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_F <= PC_RESET;
        else
            pc_F <= next_pc;
    end

    // Delay slot is always kept; only req/eret squash it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IR_D  <= 32'h0000_0000;
            PC_D  <= 32'h0000_0000;
            BD_D  <= 1'b0;
            exc_D <= 5'd0;
        end else if (req || eret) begin
            IR_D  <= 32'h0000_0000;
            PC_D  <= 32'h0000_0000;
            BD_D  <= 1'b0;
            exc_D <= 5'd0;
        end else if (!stall) begin
            IR_D  <= word_F;
            PC_D  <= pc_F;
            BD_D  <= (PCSel != 2'd0);
            exc_D <= exc_F;
        end
    end

endmodule
